// File: rtl/timer_device.sv
// timer_device: CPU-mapped down-counting timer with interrupt.
// Ports: clk, reset (sync, high), addr/we/din/dout bus, irq.
// Optional: TIMER_AUTORELOAD_EN enables MODE=01 auto-reload.
//
// Register map (addr):
//   0 CTRL   : bit0 EN, bits2:1 MODE, bit3 IM (bits31:4 read 0)
//   1 PRESET : reload value, latched into COUNT in LOAD
//   2 COUNT  : current count, read-only
//   3 -      : reads 0, writes ignored
// irq = IM & PEND, registered.
module timer_device (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ctrl;
  logic [3:0]  w_ctrl_nxt;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;
  logic        r_pend;
  logic        w_pend_nxt;
  logic        r_irq;

  logic w_en;
  logic w_auto;
  logic w_ctrl_wr;
  logic w_pre_wr;

  assign w_en      = r_ctrl[0];
  assign w_ctrl_wr = we & (addr == 2'd0);
  assign w_pre_wr  = we & (addr == 2'd1);

`ifdef TIMER_AUTORELOAD_EN
  assign w_auto = (r_ctrl[2:1] == 2'b01);
`else
  assign w_auto = 1'b0;
`endif

  // FSM next state; a CPU CTRL write is applied last so it
  // overrides the FSM's EN clear and any PEND set/clear.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl_nxt  = r_ctrl;
    w_count_nxt = r_count;
    w_pend_nxt  = r_pend;
    case (r_state)
      S_IDLE: begin
        if (w_en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!w_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          w_count_nxt = 32'd0;
          w_pend_nxt  = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (w_auto) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_LOAD;
        end else begin
          w_ctrl_nxt[0] = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_ctrl_wr) begin
      w_ctrl_nxt = din[3:0];
      w_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_pend   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_count <= w_count_nxt;
      r_pend  <= w_pend_nxt;
      // Registered from next-state values so irq lines up
      // with PEND/IM in the same cycle.
      r_irq   <= w_ctrl_nxt[3] & w_pend_nxt;
      if (w_pre_wr) r_preset <= din;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {28'd0, r_ctrl};
      2'd1:    dout = r_preset;
      2'd2:    dout = r_count;
      default: dout = 32'd0;
    endcase
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed and random checks of timer_device
// against a cycle-level behavioural model.
module tb_timer_device;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad = 0;

  timer_device dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Model: timer phase plus architectural registers.
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_INT  = 3;

  int          m_ph = PH_IDLE;
  logic [3:0]  m_ctrl = 4'd0;
  logic [31:0] m_preset = 32'd0;
  logic [31:0] m_count = 32'd0;
  logic        m_pend = 1'b0;
  logic        m_irq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_step(input logic rst, input logic w,
                        input logic [1:0] a, input logic [31:0] d);
    logic auto_m;
    if (rst) begin
      m_ctrl   = 4'd0;
      m_preset = 32'd0;
      m_count  = 32'd0;
      m_pend   = 1'b0;
      m_ph     = PH_IDLE;
    end else begin
      auto_m = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      auto_m = (m_ctrl[2:1] == 2'b01);
`endif
      case (m_ph)
        PH_IDLE: if (m_ctrl[0]) m_ph = PH_LOAD;
        PH_LOAD: begin
          m_count = m_preset;
          m_ph    = PH_CNT;
        end
        PH_CNT: begin
          if (!m_ctrl[0]) m_ph = PH_IDLE;
          else if (m_count > 1) m_count = m_count - 1;
          else begin
            m_count = 0;
            m_pend  = 1'b1;
            m_ph    = PH_INT;
          end
        end
        default: begin
          if (auto_m) begin
            m_pend = 1'b0;
            m_ph   = PH_LOAD;
          end else begin
            m_ctrl[0] = 1'b0;
            m_ph      = PH_IDLE;
          end
        end
      endcase
      if (w && a == 2'd0) begin
        m_ctrl = d[3:0];
        m_pend = 1'b0;
      end
      if (w && a == 2'd1) m_preset = d;
    end
    m_irq = m_ctrl[3] & m_pend;
  endtask

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0:       return {28'd0, m_ctrl};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: drive, edge, update model, check irq.
  task automatic step(input logic rst, input logic w,
                      input logic [1:0] a, input logic [31:0] d);
    reset = rst;
    we    = w;
    addr  = a;
    din   = d;
    @(posedge clk);
    m_step(rst, w, a, d);
    #1;
    reset = 1'b0;
    we    = 1'b0;
    chk("irq_model", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input string tag, input int a,
                    input logic [31:0] exp);
    addr = a[1:0];
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic rd_all();
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      chk("rd_model", dout, m_read(a));
    end
  endtask

  task automatic irq_is(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 2'd0, 32'd0);
    irq_is("rst_irq", 1'b0);
    rd("rst_ctrl", 0, 32'd0);
    rd("rst_pre", 1, 32'd0);
    rd("rst_cnt", 2, 32'd0);
    rd("rst_a3", 3, 32'd0);

    // One-shot, PRESET=3, CTRL=0x9: irq in cycle t+6, held
    step(1'b0, 1'b1, 2'd1, 32'd3);
    step(1'b0, 1'b1, 2'd0, 32'h9);
    irq_is("os_early", 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      irq_is("os_early", 1'b0);
    end
    idle(1);
    irq_is("os_fire", 1'b1);
    idle(3);
    irq_is("os_hold", 1'b1);
    rd("os_cnt", 2, 32'd0);
    rd("os_ctrl", 0, 32'h8);

    // CTRL=0 clears PEND, irq low next cycle, no restart
    step(1'b0, 1'b1, 2'd0, 32'h0);
    irq_is("clr_irq", 1'b0);
    idle(3);
    rd("clr_cnt", 2, 32'd0);
    rd("clr_ctrl", 0, 32'd0);

    // Upper CTRL bits ignored, writes to COUNT/addr3 ignored
    step(1'b0, 1'b1, 2'd0, 32'hFFFF_FFF0);
    rd("ctrl_hi", 0, 32'd0);
    step(1'b0, 1'b1, 2'd2, 32'h1234);
    step(1'b0, 1'b1, 2'd3, 32'h5678);
    rd("cnt_ro", 2, 32'd0);
    rd("a3_ro", 3, 32'd0);

    // PRESET=0 behaves as 1: irq at t+4
    step(1'b1, 1'b0, 2'd0, 32'd0);
    step(1'b0, 1'b1, 2'd0, 32'h9);
    idle(2);
    irq_is("p0_early", 1'b0);
    idle(1);
    irq_is("p0_fire", 1'b1);

    // IM=0 masks irq; later CTRL=0x8 leaves it low
    step(1'b1, 1'b0, 2'd0, 32'd0);
    step(1'b0, 1'b1, 2'd1, 32'd1);
    step(1'b0, 1'b1, 2'd0, 32'h1);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      irq_is("mask_lo", 1'b0);
    end
    step(1'b0, 1'b1, 2'd0, 32'h8);
    irq_is("mask_wr", 1'b0);
    idle(2);
    irq_is("mask_wr2", 1'b0);
    rd("mask_ctrl", 0, 32'h8);

    // Freeze at 6 after 4 counting cycles, reload 10 on re-enable
    step(1'b1, 1'b0, 2'd0, 32'd0);
    step(1'b0, 1'b1, 2'd1, 32'd10);
    step(1'b0, 1'b1, 2'd0, 32'h1);
    idle(5);
    rd("frz_pre", 2, 32'd7);
    step(1'b0, 1'b1, 2'd0, 32'h0);
    rd("frz_a", 2, 32'd6);
    idle(4);
    rd("frz_b", 2, 32'd6);
    step(1'b0, 1'b1, 2'd0, 32'h1);
    idle(2);
    rd("reload", 2, 32'd10);

    // Reset during counting at COUNT=5
    step(1'b1, 1'b0, 2'd0, 32'd0);
    step(1'b0, 1'b1, 2'd1, 32'd8);
    step(1'b0, 1'b1, 2'd0, 32'h9);
    idle(5);
    rd("pre_rst5", 2, 32'd5);
    step(1'b1, 1'b0, 2'd0, 32'd0);
    irq_is("mid_irq", 1'b0);
    rd("mid_ctrl", 0, 32'd0);
    rd("mid_pre", 1, 32'd0);
    rd("mid_cnt", 2, 32'd0);
    for (int i = 0; i < 12; i++) begin
      idle(1);
      irq_is("mid_quiet", 1'b0);
    end

`ifdef TIMER_AUTORELOAD_EN
    // Auto-reload: one-cycle pulses every 4 cycles
    step(1'b1, 1'b0, 2'd0, 32'd0);
    step(1'b0, 1'b1, 2'd1, 32'd2);
    step(1'b0, 1'b1, 2'd0, 32'hB);
    for (int k = 2; k <= 17; k++) begin
      idle(1);
      irq_is("ar_pulse", (k >= 5 && (k - 5) % 4 == 0));
      if (k == 3 || k == 7) rd("ar_cnt2", 2, 32'd2);
      if (k == 4 || k == 8) rd("ar_cnt1", 2, 32'd1);
      if (k == 5 || k == 9) rd("ar_cnt0", 2, 32'd0);
    end
`endif

    // Random traffic against the model
    step(1'b1, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 800; i++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 2) begin
        step(1'b1, 1'b0, 2'd0, 32'd0);
      end else if (op < 14) begin
        step(1'b0, 1'b1, 2'd0, $urandom);
      end else if (op < 24) begin
        if ($urandom_range(0, 9) == 0)
          step(1'b0, 1'b1, 2'd1, $urandom);
        else
          step(1'b0, 1'b1, 2'd1, 32'($urandom_range(0, 7)));
      end else if (op < 29) begin
        step(1'b0, 1'b1, 2'($urandom_range(2, 3)), $urandom);
      end else begin
        idle(1);
      end
      rd_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_device.md
TIMER_DEVICE -- requirements
Module: timer_device

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port addr, input, 2, word select for the CPU bridge: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-004 SHALL have port we, input, 1, CPU store strobe; the write commits at the clk edge.
REQ-005 SHALL have port din, input, 32, CPU store data.
REQ-006 SHALL have port dout, output, 32, CPU load data; combinational from addr.
REQ-007 SHALL have port irq, output, 1, interrupt request to the CPU (HWInt); registered.

Function
REQ-008 CTRL layout SHALL be: bit0 EN (enable), bits2:1 MODE, bit3 IM (interrupt mask); bits31:4 SHALL be write-ignored and read 0.
REQ-009 MODE SHALL be: 00 = one-shot, 01 = auto-reload; 10 and 11 SHALL behave as 00.
REQ-010 Reads SHALL return: addr 0 = CTRL, addr 1 = PRESET, addr 2 = COUNT, addr 3 = 0.
REQ-011 Writes to COUNT and to addr 3 SHALL be ignored.
REQ-012 A PRESET write SHALL take effect only at the next LOAD state.
REQ-013 The FSM SHALL have four states: IDLE, LOAD, CNT and INT.
REQ-014 In IDLE with EN=1, the FSM SHALL go to LOAD.
REQ-015 In LOAD, the block SHALL set COUNT to PRESET and go to CNT.
REQ-016 In CNT with EN=0, the FSM SHALL go to IDLE and hold COUNT.
REQ-017 In CNT with COUNT>1, COUNT SHALL decrement by 1.
REQ-018 In CNT with COUNT<=1, COUNT SHALL become 0, the FSM SHALL go to INT, and PEND SHALL be set at the same edge.
REQ-019 In INT with MODE=00, EN SHALL be cleared and the FSM SHALL go to IDLE.
REQ-020 In INT with auto-reload, the FSM SHALL go to LOAD.
REQ-021 irq SHALL be IM AND PEND.
REQ-022 In one-shot mode, PEND SHALL hold until a CTRL write or reset.
REQ-023 In auto-reload mode, PEND SHALL clear automatically one cycle after it is set.
REQ-024 Latency SHALL be: an EN=1 write in cycle t with PRESET=N>=1 asserts irq in cycle t+3+N.
REQ-025 PRESET=0 SHALL behave as PRESET=1, asserting irq in cycle t+4.
REQ-026 When a CTRL write coincides with an FSM-driven EN clear, the CPU write SHALL win.
REQ-027 When a CTRL write coincides with PEND being set, PEND SHALL end that cycle cleared.
REQ-028 Clearing EN mid-count SHALL freeze COUNT.
REQ-029 Re-enabling after a freeze SHALL reload from PRESET; COUNT SHALL NOT resume.
REQ-030 COUNT arithmetic SHALL be 32-bit unsigned with no wrap below 0.

Reset
REQ-031 Reset SHALL clear CTRL, PRESET, COUNT and PEND to 0, set the state to IDLE, and drive irq to 0 from the next cycle.
REQ-032 Reset SHALL override any simultaneous write or FSM transition, including reset during CNT or INT.

Configuration
REQ-033 Macro TIMER_AUTORELOAD_EN SHALL gate the auto-reload feature.
REQ-034 With TIMER_AUTORELOAD_EN defined, MODE=01 SHALL give auto-reload per REQ-020 and REQ-023.
REQ-035 Without TIMER_AUTORELOAD_EN, MODE bits SHALL be stored and read back, but all modes SHALL behave as one-shot.

Verification
REQ-036 The bench SHALL cover: reset, then PRESET=3, then CTRL=0x9 written in cycle t -> irq=1 from t+6 and held; COUNT reads 0; CTRL reads 0x8 (EN cleared).
REQ-037 The bench SHALL cover: after REQ-036, write CTRL=0x0 -> irq=0 next cycle; state IDLE.
REQ-038 The bench SHALL cover: with TIMER_AUTORELOAD_EN, PRESET=2, CTRL=0xB -> irq one-cycle pulses every 4 cycles; COUNT sequence 2,1,0,(INT),2.
REQ-039 The bench SHALL cover: PRESET=10, CTRL=0x1, then CTRL=0x0 after 4 CNT cycles -> COUNT frozen at 6; re-enable -> COUNT reloads 10.
REQ-040 The bench SHALL cover: CTRL=0x1 (IM=0) with PRESET=1 -> irq stays 0; then CTRL=0x8 -> irq stays 0 (PEND cleared by write).
REQ-041 The bench SHALL cover: reset asserted while COUNT=5 in CNT -> next cycle all register reads return 0, irq=0, and no irq follows.
